// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core instruction arbiter.
package tensor_core_pkg;

    typedef logic [15:0] instruction_t;

    localparam instruction_t TC_NOP = 16'h0000;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at NUM_REQ-1.
module rr_priority_picker
    import tensor_core_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any_valid
);

    logic [PTR_W:0] sum;

    // Scan from the farthest offset down so the offset closest to ptr is written last and wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            if (req[sum[PTR_W-1:0]]) begin
                winner    = sum[PTR_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tensor_core_instruction_arbiter.sv
// Shares one tensor core controller among NUM_REQ instruction sources with atomic, round-robin
// granted sequences, and routes each result byte back to the requester that issued it.
module tensor_core_instruction_arbiter
    import tensor_core_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int INSTR_WIDTH    = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_BURST      = 16,
    parameter int RESULT_LATENCY = 1
) (
    input  logic                           clock_in,
    input  logic                           reset_in,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ*INSTR_WIDTH-1:0] req_instruction_in,
    input  logic [NUM_REQ-1:0]             req_last_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    input  logic                           core_ready_in,
    output logic [INSTR_WIDTH-1:0]         current_tensor_core_instruction,
    output logic                           instruction_valid_out,
    input  logic [DATA_WIDTH-1:0]          tensor_core_controller_output,
    output logic [DATA_WIDTH-1:0]          result_data_out,
    output logic [NUM_REQ-1:0]             result_valid_out,
    output logic [$clog2(NUM_REQ)-1:0]     grant_owner_out,
    output logic                           busy_out,
    output logic                           overrun_out
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(TC_NOP);

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] owner;
    } tag_t;

    arb_state_t         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   next_ptr;
    logic               any_valid;
    logic [BURST_W-1:0] burst_cnt;
    logic               transfer;
    logic               owner_last;
    logic               burst_limit;
    logic [INSTR_WIDTH-1:0] owner_instr;
    tag_t               tag_pipe [RESULT_LATENCY];
    tag_t               tag_head;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req       (req_valid_in),
        .ptr       (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Handshake: a requester's instruction moves when its valid and ready are both high on a rising
    // edge; ready is only offered to the grant owner and simply mirrors core_ready_in.
    always_comb begin
        req_ready_out = '0;
        if (state == ARB_GRANT) begin
            req_ready_out[owner] = core_ready_in;
        end
    end

    assign owner_instr = req_instruction_in[int'(owner)*INSTR_WIDTH +: INSTR_WIDTH];
    assign owner_last  = req_last_in[owner];
    assign transfer    = (state == ARB_GRANT) && req_valid_in[owner] && core_ready_in;
    assign burst_limit = (burst_cnt == BURST_W'(MAX_BURST - 1));
    assign next_ptr    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state                           <= ARB_IDLE;
            rr_ptr                          <= '0;
            owner                           <= '0;
            burst_cnt                       <= '0;
            current_tensor_core_instruction <= NOP;
            instruction_valid_out           <= 1'b0;
            overrun_out                     <= 1'b0;
        end else begin
            current_tensor_core_instruction <= NOP;
            instruction_valid_out           <= 1'b0;
            overrun_out                     <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (any_valid) begin
                        owner <= winner;
                        state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (transfer) begin
                        current_tensor_core_instruction <= owner_instr;
                        instruction_valid_out           <= 1'b1;
                        // A last on the MAX_BURST-th beat is a normal release, not an overrun.
                        if (owner_last || burst_limit) begin
                            state       <= ARB_IDLE;
                            rr_ptr      <= next_ptr;
                            burst_cnt   <= '0;
                            overrun_out <= !owner_last;
                        end else begin
                            burst_cnt <= burst_cnt + BURST_W'(1);
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Owner is still the issuer while its instruction is on the output, so tags stay correct
    // across grant changes without draining.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < RESULT_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: instruction_valid_out, owner: owner};
            for (int i = 1; i < RESULT_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_head = tag_pipe[RESULT_LATENCY-1];

    always_comb begin
        result_valid_out = '0;
        if (tag_head.valid) begin
            result_valid_out[tag_head.owner] = 1'b1;
        end
    end

    assign result_data_out = tensor_core_controller_output;
    assign grant_owner_out = owner;
    assign busy_out        = (state == ARB_GRANT);

endmodule
